// File: rtl/pipeline_front_end_pkg.sv
// Shared MIPS core constants and the ID-stage control bundle type used by
// the front end, the decoder and the hazard unit.
package mips_pkg;

  localparam int          WIDTH_DEFAULT = 32;
  localparam int          CTRL_W        = 9;
  localparam int          PC_STEP       = 4;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
  localparam logic [31:0] RESET_PC      = 32'h0000_0000;

  typedef logic [CTRL_W-1:0] ctrlBundle_t;

endpackage

// File: rtl/pipeline_front_end_if.sv
// Fetch-side bundle: hazard/branch inputs toward the front end and the
// registered PC, IF/ID, ID/EX and statistics outputs coming back.
interface pipeline_front_end_if #(
  parameter int WIDTH  = mips_pkg::WIDTH_DEFAULT,
  parameter int CTRL_W = mips_pkg::CTRL_W,
  parameter int CNT_W  = 16
);

  logic              pcHOLD;
  logic              IFIDRegHOLD;
  logic              controlMUX;
  logic              branchTaken;
  logic [WIDTH-1:0]  branchTarget;
  logic [WIDTH-1:0]  instrIn;
  logic [CTRL_W-1:0] ctrlIn;

  logic [WIDTH-1:0]  pc;
  logic [WIDTH-1:0]  ifidInstr;
  logic [WIDTH-1:0]  ifidPcPlus4;
  logic              ifidValid;
  logic [CTRL_W-1:0] idexCtrl;
  logic              idexValid;
  logic [CNT_W-1:0]  stallCount;
  logic [CNT_W-1:0]  flushCount;
  logic              stallError;
  logic              protocolError;

  modport master (
    output pcHOLD, IFIDRegHOLD, controlMUX, branchTaken, branchTarget, instrIn, ctrlIn,
    input  pc, ifidInstr, ifidPcPlus4, ifidValid, idexCtrl, idexValid,
    input  stallCount, flushCount, stallError, protocolError
  );

  modport slave (
    input  pcHOLD, IFIDRegHOLD, controlMUX, branchTaken, branchTarget, instrIn, ctrlIn,
    output pc, ifidInstr, ifidPcPlus4, ifidValid, idexCtrl, idexValid,
    output stallCount, flushCount, stallError, protocolError
  );

endinterface

// File: rtl/pipeline_front_end_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_front_end.sv
// Fetch-side pipeline control: PC, IF/ID and ID/EX bubble registers driven by
// the hazard-unit stall handshake and branch flush, plus stall/flush monitoring.
module pipeline_front_end #(
  parameter int               WIDTH     = mips_pkg::WIDTH_DEFAULT,
  parameter int               CTRL_W    = mips_pkg::CTRL_W,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(mips_pkg::RESET_PC),
  parameter int               MAX_STALL = 4,
  parameter int               CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_front_end_if.slave  bus
);

  import mips_pkg::NOP_INSTR;
  import mips_pkg::PC_STEP;

  localparam int             RUN_W     = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL + 1);

  logic [WIDTH-1:0]  pcReg;
  logic [WIDTH-1:0]  pcPlus4;
  logic [WIDTH-1:0]  ifidInstrReg;
  logic [WIDTH-1:0]  ifidPcPlus4Reg;
  logic              ifidValidReg;
  logic [CTRL_W-1:0] idexCtrlReg;
  logic              idexValidReg;
  logic [RUN_W-1:0]  stallRun;
  logic [RUN_W-1:0]  runNext;
  logic              stallErrorReg;
  logic              protocolErrorReg;
  logic              stallCycle;
  logic              holdsDisagree;
  logic [CNT_W-1:0]  stallCountW;
  logic [CNT_W-1:0]  flushCountW;

  assign pcPlus4       = pcReg + WIDTH'(PC_STEP);
  assign stallCycle    = bus.controlMUX && !bus.branchTaken;
  assign holdsDisagree = (bus.pcHOLD != bus.IFIDRegHOLD) || (bus.pcHOLD != bus.controlMUX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcReg <= RESET_PC;
    end else if (bus.branchTaken) begin
      pcReg <= bus.branchTarget;
    end else if (!bus.pcHOLD) begin
      pcReg <= pcPlus4;
    end
  end

  // A flush squashes whatever was fetched this cycle; a hold keeps the slot as is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifidInstr_reset: begin
        ifidInstrReg   <= '0;
        ifidPcPlus4Reg <= '0;
        ifidValidReg   <= 1'b0;
      end
    end else if (bus.branchTaken) begin
      ifidInstrReg   <= WIDTH'(NOP_INSTR);
      ifidPcPlus4Reg <= '0;
      ifidValidReg   <= 1'b0;
    end else if (!bus.IFIDRegHOLD) begin
      ifidInstrReg   <= bus.instrIn;
      ifidPcPlus4Reg <= pcPlus4;
      ifidValidReg   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idexCtrlReg  <= '0;
      idexValidReg <= 1'b0;
    end else if (bus.branchTaken || bus.controlMUX || !ifidValidReg) begin
      idexCtrlReg  <= '0;
      idexValidReg <= 1'b0;
    end else begin
      idexCtrlReg  <= bus.ctrlIn;
      idexValidReg <= 1'b1;
    end
  end

  // Length of the current back-to-back stall run, pinned once it is over the limit.
  always_comb begin
    runNext = '0;
    if (stallCycle) begin
      runNext = (stallRun == RUN_LIMIT) ? stallRun : stallRun + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallRun         <= '0;
      stallErrorReg    <= 1'b0;
      protocolErrorReg <= 1'b0;
    end else begin
      stallRun <= runNext;
      if (runNext == RUN_LIMIT) begin
        stallErrorReg <= 1'b1;
      end
      if (holdsDisagree) begin
        protocolErrorReg <= 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) stallCounter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stallCycle),
    .count (stallCountW)
  );

  sat_counter #(.WIDTH(CNT_W)) flushCounter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.branchTaken),
    .count (flushCountW)
  );

  assign bus.pc            = pcReg;
  assign bus.ifidInstr     = ifidInstrReg;
  assign bus.ifidPcPlus4   = ifidPcPlus4Reg;
  assign bus.ifidValid     = ifidValidReg;
  assign bus.idexCtrl      = idexCtrlReg;
  assign bus.idexValid     = idexValidReg;
  assign bus.stallCount    = stallCountW;
  assign bus.flushCount    = flushCountW;
  assign bus.stallError    = stallErrorReg;
  assign bus.protocolError = protocolErrorReg;

endmodule

// File: tb/tb_pipeline_front_end.sv
// Directed, table-driven bench for pipeline_front_end: one vector per clock
// edge with hand-computed expected register contents, then an async reset probe.
module tb_pipeline_front_end;

  import mips_pkg::ctrlBundle_t;

  localparam int WIDTH  = 32;
  localparam int CTRL_W = 9;
  localparam int CNT_W  = 16;

  typedef struct {
    logic        pcHold;
    logic        ifidHold;
    logic        ctrlMux;
    logic        branch;
    logic [31:0] target;
    logic [31:0] instr;
    ctrlBundle_t ctrl;
    logic [31:0] expPc;
    logic [31:0] expInstr;
    logic [31:0] expPcPlus4;
    logic        expIfidValid;
    ctrlBundle_t expCtrl;
    logic        expIdexValid;
    logic [15:0] expStall;
    logic [15:0] expFlush;
    logic        expStallErr;
    logic        expProtoErr;
  } vector_t;

  logic clk;
  logic rst_n;
  int   assertions;
  int   failures;
  vector_t vecs[$];

  pipeline_front_end_if #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  pipeline_front_end #(
    .WIDTH     (WIDTH),
    .CTRL_W    (CTRL_W),
    .RESET_PC  (32'h0000_0000),
    .MAX_STALL (4),
    .CNT_W     (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vector_t v);
    bus.pcHOLD       = v.pcHold;
    bus.IFIDRegHOLD  = v.ifidHold;
    bus.controlMUX   = v.ctrlMux;
    bus.branchTaken  = v.branch;
    bus.branchTarget = v.target;
    bus.instrIn      = v.instr;
    bus.ctrlIn       = v.ctrl;
  endtask

  task automatic checkVector(input int idx, input vector_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    checkOutput({tag, " pc"},            bus.pc,                    v.expPc);
    checkOutput({tag, " ifidInstr"},     bus.ifidInstr,             v.expInstr);
    checkOutput({tag, " ifidPcPlus4"},   bus.ifidPcPlus4,           v.expPcPlus4);
    checkOutput({tag, " ifidValid"},     32'(bus.ifidValid),        32'(v.expIfidValid));
    checkOutput({tag, " idexCtrl"},      32'(bus.idexCtrl),         32'(v.expCtrl));
    checkOutput({tag, " idexValid"},     32'(bus.idexValid),        32'(v.expIdexValid));
    checkOutput({tag, " stallCount"},    32'(bus.stallCount),       32'(v.expStall));
    checkOutput({tag, " flushCount"},    32'(bus.flushCount),       32'(v.expFlush));
    checkOutput({tag, " stallError"},    32'(bus.stallError),       32'(v.expStallErr));
    checkOutput({tag, " protocolError"}, 32'(bus.protocolError),    32'(v.expProtoErr));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " pc"},            bus.pc,                 32'h0);
    checkOutput({tag, " ifidInstr"},     bus.ifidInstr,          32'h0);
    checkOutput({tag, " ifidPcPlus4"},   bus.ifidPcPlus4,        32'h0);
    checkOutput({tag, " ifidValid"},     32'(bus.ifidValid),     32'h0);
    checkOutput({tag, " idexCtrl"},      32'(bus.idexCtrl),      32'h0);
    checkOutput({tag, " idexValid"},     32'(bus.idexValid),     32'h0);
    checkOutput({tag, " stallCount"},    32'(bus.stallCount),    32'h0);
    checkOutput({tag, " flushCount"},    32'(bus.flushCount),    32'h0);
    checkOutput({tag, " stallError"},    32'(bus.stallError),    32'h0);
    checkOutput({tag, " protocolError"}, 32'(bus.protocolError), 32'h0);
  endtask

  // Each row: holds/branch/target/instr/ctrl applied before an edge, then the
  // register contents expected just after that edge.
  initial begin
    assertions = 0;
    failures   = 0;

    //               pH ifH mux br target        instr          ctrl    | pc            ifidInstr      pc+4          iv  idexCtrl iev stall  flush  sE pE
    vecs.push_back('{0, 0, 0, 0, 32'h0,         32'h8C01_0000, 9'h011, 32'h4,        32'h8C01_0000, 32'h4,        1, 9'h000, 0, 16'd0, 16'd0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 32'h0,         32'h0022_1820, 9'h055, 32'h8,        32'h0022_1820, 32'h8,        1, 9'h055, 1, 16'd0, 16'd0, 0, 0});
    vecs.push_back('{1, 1, 1, 0, 32'h0,         32'hAAAA_0001, 9'h0F0, 32'h8,        32'h0022_1820, 32'h8,        1, 9'h000, 0, 16'd1, 16'd0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 32'h0,         32'h1111_1111, 9'h101, 32'hC,        32'h1111_1111, 32'hC,        1, 9'h101, 1, 16'd1, 16'd0, 0, 0});
    vecs.push_back('{1, 1, 1, 1, 32'h40,        32'h2222_2222, 9'h1FF, 32'h40,       32'h0,         32'h0,        0, 9'h000, 0, 16'd1, 16'd1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 32'h0,         32'h3333_3333, 9'h0AA, 32'h44,       32'h3333_3333, 32'h44,       1, 9'h000, 0, 16'd1, 16'd1, 0, 0});
    vecs.push_back('{1, 1, 1, 0, 32'h0,         32'hDEAD_BEEF, 9'h0CC, 32'h44,       32'h3333_3333, 32'h44,       1, 9'h000, 0, 16'd2, 16'd1, 0, 0});
    vecs.push_back('{1, 1, 1, 0, 32'h0,         32'hDEAD_BEEF, 9'h0CC, 32'h44,       32'h3333_3333, 32'h44,       1, 9'h000, 0, 16'd3, 16'd1, 0, 0});
    vecs.push_back('{1, 1, 1, 0, 32'h0,         32'hDEAD_BEEF, 9'h0CC, 32'h44,       32'h3333_3333, 32'h44,       1, 9'h000, 0, 16'd4, 16'd1, 0, 0});
    vecs.push_back('{1, 1, 1, 0, 32'h0,         32'hDEAD_BEEF, 9'h0CC, 32'h44,       32'h3333_3333, 32'h44,       1, 9'h000, 0, 16'd5, 16'd1, 0, 0});
    vecs.push_back('{1, 1, 1, 0, 32'h0,         32'hDEAD_BEEF, 9'h0CC, 32'h44,       32'h3333_3333, 32'h44,       1, 9'h000, 0, 16'd6, 16'd1, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 32'h0,         32'h4444_4444, 9'h003, 32'h48,       32'h4444_4444, 32'h48,       1, 9'h003, 1, 16'd6, 16'd1, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 32'h0,         32'h5555_5555, 9'h077, 32'h48,       32'h5555_5555, 32'h4C,       1, 9'h077, 1, 16'd6, 16'd1, 1, 1});
    vecs.push_back('{0, 0, 0, 1, 32'hFFFF_FFFC, 32'h6666_6666, 9'h001, 32'hFFFF_FFFC, 32'h0,         32'h0,        0, 9'h000, 0, 16'd6, 16'd2, 1, 1});
    vecs.push_back('{0, 0, 0, 0, 32'h0,         32'h7777_7777, 9'h01E, 32'h0,        32'h7777_7777, 32'h0,        1, 9'h000, 0, 16'd6, 16'd2, 1, 1});
    vecs.push_back('{0, 0, 0, 0, 32'h0,         32'h8888_8888, 9'h019, 32'h4,        32'h8888_8888, 32'h4,        1, 9'h019, 1, 16'd6, 16'd2, 1, 1});

    rst_n            = 1'b0;
    bus.pcHOLD       = 1'b0;
    bus.IFIDRegHOLD  = 1'b0;
    bus.controlMUX   = 1'b0;
    bus.branchTaken  = 1'b0;
    bus.branchTarget = '0;
    bus.instrIn      = '0;
    bus.ctrlIn       = '0;

    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkVector(i, vecs[i]);
    end

    // Mid-cycle reset pulse must clear everything without waiting for an edge.
    @(negedge clk);
    applyStimulus('{0, 0, 0, 0, 32'h0, 32'h9999_9999, 9'h033, 32'h0, 32'h0, 32'h0, 0, 9'h0, 0, 16'd0, 16'd0, 0, 0});
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("asyncReset");
    @(posedge clk);
    #1;
    checkResetState("heldReset");

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_front_end.md
# pipeline_front_end

Fetch-side pipeline control for the 5-stage MIPS core: owns the PC register, the IF/ID pipeline register and the ID/EX control-bubble register. It consumes the load-use stall handshake produced by the hazard detection unit (`pcHOLD`, `IFIDRegHOLD`, `controlMUX`) together with the branch-flush request. It also checks that the handshake is self-consistent and keeps stall/flush statistics.

## Interface
- `WIDTH`, 32, PC and instruction width
- `CTRL_W`, 9, decoded ID-stage control bundle width
- `RESET_PC`, 32'h0000_0000, PC value after reset
- `MAX_STALL`, 4, longest legal run of consecutive stall cycles
- `CNT_W`, 16, statistics counter width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `pcHOLD`  in  1  freeze PC this cycle
- `IFIDRegHOLD`  in  1  freeze IF/ID register this cycle
- `controlMUX`  in  1  insert bubble (zero control) into ID/EX
- `branchTaken`  in  1  redirect fetch and flush IF/ID and ID/EX
- `branchTarget`  in  WIDTH  redirect address
- `instrIn`  in  WIDTH  instruction memory read data for current `pc` (combinational)
- `ctrlIn`  in  CTRL_W  control bundle decoded from `ifidInstr`
- `pc`  out  WIDTH  fetch address
- `ifidInstr`  out  WIDTH  IF/ID instruction
- `ifidPcPlus4`  out  WIDTH  IF/ID PC+4
- `ifidValid`  out  1  IF/ID holds a real instruction
- `idexCtrl`  out  CTRL_W  ID/EX control bundle
- `idexValid`  out  1  ID/EX holds a real instruction
- `stallCount`  out  CNT_W  total stall cycles, saturating
- `flushCount`  out  CNT_W  total flush cycles, saturating
- `stallError`  out  1  sticky: stall run exceeded `MAX_STALL`
- `protocolError`  out  1  sticky: hold/bubble inputs disagreed

## Operation
- Per-edge priority: reset > `branchTaken` > holds > normal advance.
- PC:
  - `branchTaken` → `branchTarget`.
  - Else if `pcHOLD` → unchanged.
  - Else → `pc+4`, wrapping modulo 2^WIDTH.
- IF/ID:
  - `branchTaken` → `ifidInstr`=0 (NOP), `ifidPcPlus4`=0, `ifidValid`=0.
  - Else if `IFIDRegHOLD` → all three unchanged.
  - Else → `instrIn`, `pc+4`, `ifidValid`=1.
- ID/EX:
  - `branchTaken`, `controlMUX`, or `!ifidValid` → `idexCtrl`=0, `idexValid`=0.
  - Else → `ctrlIn`, `idexValid`=1.
- Stall run counter (internal, width ⌈log2(MAX_STALL+2)⌉):
  - Increments each cycle `controlMUX`=1 and `branchTaken`=0.
  - Clears otherwise.
  - Saturates at MAX_STALL+1.
  - Reaching MAX_STALL+1 sets `stallError`.
- `stallCount` increments on every cycle with `controlMUX`=1 and `branchTaken`=0. `flushCount` increments on every `branchTaken`=1 cycle. Both hold at all-ones.
- `protocolError` is set on any edge where `pcHOLD`, `IFIDRegHOLD` and `controlMUX` are not all equal. The datapath still obeys each input individually.
- Simultaneous `branchTaken` and holds: the flush wins. PC takes the target, IF/ID and ID/EX are cleared, and the cycle is not counted as a stall.
- Error flags clear only on reset.

## Timing
- Every output is registered. Inputs act at the next rising edge (1-cycle latency). There is no combinational path from any input to any output.
- Reset values: `pc`=RESET_PC; all other outputs 0.
- Reset assertion acts immediately, mid-operation included, without waiting for an edge. Release is synchronous to the next edge.
- First edge after reset release: IF/ID captures `instrIn` for RESET_PC, and `pc` becomes RESET_PC+4.
- A one-cycle load-use stall (all three inputs high for one edge) produces:
  - `pc` and IF/ID unchanged for one cycle;
  - exactly one bubble in ID/EX (`idexValid`=0 for one cycle);
  - `stallCount` +1.
- A branch produces one invalid IF/ID cycle and one invalid ID/EX cycle. The fetch at `branchTarget` appears in IF/ID on the following edge.

## Structure
- Shared package `mips_pkg`:
  - `NOP_INSTR` (32'h0)
  - `PC_STEP` (4)
  - default `RESET_PC`
  - `CTRL_W`
  - a typedef for the control bundle, shared with the decoder and the hazard unit
- One sub-module, `sat_counter` (parameter width; inputs `clk`, `rst_n`, `inc`; output count that holds at max). Instantiated twice, for `stallCount` and `flushCount`.

## Test plan
- Reset and free-run: `rst_n` low, `pc`=0. Release with `instrIn`=32'h8C01_0000 → after the edge `pc`=4, `ifidInstr`=32'h8C01_0000, `ifidPcPlus4`=4, `ifidValid`=1. After a further edge `idexValid`=1.
- Load-use stall: at `pc`=8, drive all three holds high for one edge → `pc` stays 8, IF/ID unchanged, `idexCtrl`=0, `idexValid`=0, `stallCount`=1. The next edge advances `pc` to 12.
- Branch with simultaneous stall: `branchTaken`=1, `branchTarget`=32'h40, all holds high → `pc`=32'h40, `ifidValid`=0, `idexValid`=0, `flushCount`=1, `stallCount` unchanged.
- Stall overrun: holds high for 5 consecutive edges with `MAX_STALL`=4 → `stallError`=1 on the 5th edge and stays 1 after the holds drop; `stallCount`=5.
- Protocol check and wrap/async reset:
  - `pcHOLD`=1 with `IFIDRegHOLD`=0 → `protocolError`=1, `pc` held, IF/ID advanced.
  - `pc`=32'hFFFF_FFFC → wraps to 0.
  - Pulse `rst_n` low mid-cycle → all outputs return to reset values before the next edge.
